// File: rtl/dma_io_pkg.sv
// Shared types and register map for the dma_io_port peripheral.
package dma_io_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_XFER = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } dma_state_t;

  localparam int REG_CTRL   = 0;
  localparam int REG_COUNT  = 1;
  localparam int REG_STATUS = 2;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_DIR = 1;
  localparam int CTRL_CLR = 2;

endpackage

// File: rtl/dma_io_ram.sv
// DEPTH x DATA_W buffer: shared write port where a DMA write beats a CPU write
// to the same entry, plus two asynchronous read ports (CPU and DMA side).
module dma_io_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_cpu_we,
  input  logic [PW-1:0]     i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_dma_we,
  input  logic [PW-1:0]     i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  input  logic [PW-1:0]     i_rd_a_addr,
  output logic [DATA_W-1:0] o_rd_a_data,
  input  logic [PW-1:0]     i_rd_b_addr,
  output logic [DATA_W-1:0] o_rd_b_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_cpu_blocked;

  assign w_cpu_blocked = i_dma_we && (i_dma_addr == i_cpu_addr);

  always_ff @(posedge i_clk) begin
    if (i_cpu_we && !w_cpu_blocked) begin
      r_mem[i_cpu_addr] <= i_cpu_wdata;
    end
    if (i_dma_we) begin
      r_mem[i_dma_addr] <= i_dma_wdata;
    end
  end

  assign o_rd_a_data = r_mem[i_rd_a_addr];
  assign o_rd_b_data = r_mem[i_rd_b_addr];

endmodule

// File: rtl/dma_io_port.sv
// DMA-capable I/O port: CPU-programmed buffer moved to/from memory by the 8237.
//   state  | meaning
//   IDLE   | waiting for EN=1, COUNT!=0 and done=0
//   REQ    | dreq high, waiting for dack plus the strobe matching DIR
//   XFER   | one-cycle data phase, ready high, buffer addressed by ptr
//   WAIT   | outputs held until memory side finishes (DIR=0) or at once (DIR=1)
//   DONE   | terminal count reached, done high until CPU CLR
module dma_io_port
  import dma_io_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16,
  parameter int PW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_wr,
  input  logic              i_cpu_rd,
  input  logic [PW:0]       i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_dreq,
  input  logic              i_dack,
  input  logic              i_ior,
  input  logic              i_iow,
  input  logic              i_ready_mem,
  input  logic [DATA_W-1:0] i_bus_din,
  output logic [DATA_W-1:0] o_bus_dout,
  output logic              o_bus_oe,
  output logic [ADDR_W-1:0] o_addr_out,
  output logic              o_ready,
  output logic              o_done
);

  localparam logic [PW-1:0] A_CTRL   = PW'(REG_CTRL);
  localparam logic [PW-1:0] A_COUNT  = PW'(REG_COUNT);
  localparam logic [PW-1:0] A_STATUS = PW'(REG_STATUS);

  dma_state_t        r_state;
  dma_state_t        w_state_nxt;
  logic [PW-1:0]     r_ptr;
  logic [DATA_W-1:0] r_count;
  logic              r_en;
  logic              r_dir;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic              w_cpu_reg;
  logic [PW-1:0]     w_cpu_idx;
  logic              w_wr_ctrl;
  logic              w_wr_count;
  logic              w_clr;
  logic              w_buf_we;
  logic              w_dma_we;
  logic [DATA_W-1:0] w_cpu_buf_rdata;
  logic [DATA_W-1:0] w_dma_rdata;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd_mux;
  logic [DATA_W-1:0] w_count_dec;
  logic              w_strobe_ok;
  logic              w_strobe_bad;
  logic              w_step;
  logic              w_abort;
  logic              w_mismatch;
  logic              w_busy;
  logic              w_active;

  assign w_cpu_reg   = i_cpu_addr[PW];
  assign w_cpu_idx   = i_cpu_addr[PW-1:0];
  assign w_wr_ctrl   = i_cpu_wr && w_cpu_reg && (w_cpu_idx == A_CTRL);
  assign w_wr_count  = i_cpu_wr && w_cpu_reg && (w_cpu_idx == A_COUNT);
  assign w_clr       = w_wr_ctrl && i_cpu_wdata[CTRL_CLR];
  assign w_buf_we    = i_cpu_wr && !w_cpu_reg;
  assign w_count_dec = r_count - 1'b1;

  // Exactly one strobe, and it must be the one DIR asks for.
  assign w_strobe_ok  = r_dir ? (i_iow && !i_ior) : (i_ior && !i_iow);
  assign w_strobe_bad = i_dack && (i_ior || i_iow) && !w_strobe_ok;

  assign w_active = (r_state == S_XFER) || (r_state == S_WAIT);
  assign w_busy   = (r_state == S_REQ) || w_active;
  // The memory-to-device write lands on the edge that leaves XFER, even if that edge aborts.
  assign w_dma_we = (r_state == S_XFER) && r_dir;

  dma_io_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PW     (PW)
  ) u_ram (
    .i_clk       (i_clk),
    .i_cpu_we    (w_buf_we),
    .i_cpu_addr  (w_cpu_idx),
    .i_cpu_wdata (i_cpu_wdata),
    .i_dma_we    (w_dma_we),
    .i_dma_addr  (r_ptr),
    .i_dma_wdata (i_bus_din),
    .i_rd_a_addr (w_cpu_idx),
    .o_rd_a_data (w_cpu_buf_rdata),
    .i_rd_b_addr (r_ptr),
    .o_rd_b_data (w_dma_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_abort     = 1'b0;
    w_mismatch  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en && (r_count != '0) && !r_done) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (!r_en || (r_count == '0)) begin
          w_state_nxt = S_IDLE;
        end else if (i_dack && w_strobe_ok) begin
          w_state_nxt = S_XFER;
        end else if (w_strobe_bad) begin
          w_mismatch = 1'b1;
        end
      end
      S_XFER: begin
        if (!i_dack) begin
          w_abort     = 1'b1;
          w_state_nxt = r_en ? S_REQ : S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_dack) begin
          w_abort     = 1'b1;
          w_state_nxt = r_en ? S_REQ : S_IDLE;
        end else if (r_dir || i_ready_mem) begin
          w_step = 1'b1;
          if (w_count_dec == '0) begin
            w_state_nxt = S_DONE;
          end else if (!r_en) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_DONE: begin
        if (w_clr) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_status           = '0;
    w_status[PW-1:0]   = r_ptr;
    w_status[PW]       = w_busy;
    w_status[PW+1]     = r_done;
    w_status[PW+2]     = r_err;
  end

  always_comb begin
    w_rd_mux = '0;
    if (!w_cpu_reg) begin
      w_rd_mux = w_cpu_buf_rdata;
    end else begin
      case (w_cpu_idx)
        A_CTRL: begin
          w_rd_mux[CTRL_EN]  = r_en;
          w_rd_mux[CTRL_DIR] = r_dir;
        end
        A_COUNT:  w_rd_mux = r_count;
        A_STATUS: w_rd_mux = w_status;
        default:  w_rd_mux = '0;
      endcase
    end
  end

  // CPU register writes are applied after the FSM updates so they take precedence.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_count     <= '0;
      r_en        <= 1'b0;
      r_dir       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_step) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= w_count_dec;
        if (w_count_dec == '0) begin
          r_done <= 1'b1;
        end
      end
      if (w_abort || w_mismatch) begin
        r_err <= 1'b1;
      end
      if (w_wr_ctrl) begin
        r_en  <= i_cpu_wdata[CTRL_EN];
        r_dir <= i_cpu_wdata[CTRL_DIR];
        if (w_clr) begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          r_ptr  <= '0;
        end
      end
      if (w_wr_count) begin
        r_count <= i_cpu_wdata;
        r_ptr   <= '0;
      end
      if (i_cpu_rd) begin
        r_cpu_rdata <= w_rd_mux;
      end
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dreq      = (r_state == S_REQ);
  assign o_ready     = w_active;
  assign o_bus_oe    = w_active && !r_dir;
  assign o_bus_dout  = o_bus_oe ? w_dma_rdata : '0;
  assign o_addr_out  = w_active ? {{(ADDR_W-PW){1'b0}}, r_ptr} : '0;
  assign o_done      = r_done;

endmodule

// File: tb/tb_dma_io_port.sv
// Directed-sequence bench with randomized data and memory latency, checked against
// a transfer-level model of the buffer, pointer, count and status flags.
module tb_dma_io_port;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 16;
  localparam int PW     = 4;

  localparam logic [PW:0] A_CTRL   = 5'h10;
  localparam logic [PW:0] A_COUNT  = 5'h11;
  localparam logic [PW:0] A_STATUS = 5'h12;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              cpu_wr    = 1'b0;
  logic              cpu_rd    = 1'b0;
  logic [PW:0]       cpu_addr  = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dreq;
  logic              dack      = 1'b0;
  logic              ior       = 1'b0;
  logic              iow       = 1'b0;
  logic              ready_mem = 1'b0;
  logic [DATA_W-1:0] bus_din   = '0;
  logic [DATA_W-1:0] bus_dout;
  logic              bus_oe;
  logic [ADDR_W-1:0] addr_out;
  logic              ready;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_count;
  int                m_ptr;
  bit                m_done;
  bit                m_err;

  always #5 clk = ~clk;

  dma_io_port #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cpu_wr    (cpu_wr),
    .i_cpu_rd    (cpu_rd),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_dreq      (dreq),
    .i_dack      (dack),
    .i_ior       (ior),
    .i_iow       (iow),
    .i_ready_mem (ready_mem),
    .i_bus_din   (bus_din),
    .o_bus_dout  (bus_dout),
    .o_bus_oe    (bus_oe),
    .o_addr_out  (addr_out),
    .o_ready     (ready),
    .o_done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    return (32'(m_err) << (PW + 2)) | (32'(m_done) << (PW + 1)) | (32'(busy) << PW) | 32'(m_ptr);
  endfunction

  task automatic cpu_write(input logic [PW:0] a, input logic [DATA_W-1:0] d);
    cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [PW:0] a, output logic [DATA_W-1:0] d);
    cpu_rd = 1'b1; cpu_addr = a;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    d = cpu_rdata;
  endtask

  task automatic wait_dreq();
    int n = 0;
    while (dreq !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("dreq_wait", dreq, 1);
  endtask

  // One complete transfer; lat = WAIT cycles before ready_mem for device->memory.
  task automatic dma_xfer(input bit dir, input logic [DATA_W-1:0] din, input int lat);
    wait_dreq();
    dack = 1'b1;
    if (dir) begin iow = 1'b1; bus_din = din; end
    else ior = 1'b1;
    @(posedge clk); #1;
    check("xfer_ready", ready, 1);
    check("xfer_addr", addr_out, m_ptr);
    check("xfer_oe", bus_oe, !dir);
    check("xfer_dreq_low", dreq, 0);
    if (!dir) check("xfer_data", bus_dout, m_mem[m_ptr]);
    @(posedge clk); #1;
    check("wait_ready", ready, 1);
    if (dir) begin
      m_mem[m_ptr] = din;
    end else begin
      for (int i = 1; i < lat; i++) begin
        @(posedge clk); #1;
        check("wait_hold_data", bus_dout, m_mem[m_ptr]);
      end
      ready_mem = 1'b1;
    end
    @(posedge clk); #1;
    ready_mem = 1'b0; dack = 1'b0; ior = 1'b0; iow = 1'b0;
    m_ptr   = (m_ptr + 1) % DEPTH;
    m_count = m_count - 1;
    if (m_count == 0) m_done = 1'b1;
    check("post_dreq", dreq, (m_count != 0));
    check("post_done", done, m_done);
    check("post_ready", ready, 0);
  endtask

  task automatic model_clr();
    m_done = 1'b0; m_err = 1'b0; m_ptr = 0;
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] wvals [3];
    wvals[0] = 8'hA5; wvals[1] = 8'h5A; wvals[2] = 8'hFF;
    m_count = 0; m_ptr = 0; m_done = 1'b0; m_err = 1'b0;

    // Reset state
    #12;
    check("rst_dreq", dreq, 0);
    check("rst_ready", ready, 0);
    check("rst_oe", bus_oe, 0);
    check("rst_dout", bus_dout, 0);
    check("rst_addr", addr_out, 0);
    check("rst_done", done, 0);
    check("rst_rdata", cpu_rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cpu_read(A_STATUS, rd); check("rst_status", rd, exp_status(1'b0));
    cpu_read(A_COUNT, rd);  check("rst_count", rd, 0);

    for (int i = 0; i < DEPTH; i++) begin
      cpu_write(5'(i), 8'(i));
      m_mem[i] = 8'(i);
    end

    // Device->memory, COUNT=4
    cpu_write(A_COUNT, 8'd4); m_count = 4; m_ptr = 0;
    cpu_write(A_CTRL, 8'h01);
    check("en_dreq_not_yet", dreq, 0);
    @(posedge clk); #1;
    check("en_dreq_rise", dreq, 1);
    for (int k = 0; k < 4; k++) dma_xfer(1'b0, 8'h00, int'($urandom_range(1, 3)));
    check("t1_done", done, 1);
    check("t1_dreq", dreq, 0);
    cpu_read(A_STATUS, rd); check("t1_status", rd, exp_status(1'b0));

    // Memory->device, COUNT=3
    cpu_write(A_CTRL, 8'h04); model_clr();
    check("t2_clr_done", done, 0);
    cpu_write(A_COUNT, 8'd3); m_count = 3; m_ptr = 0;
    cpu_write(A_CTRL, 8'h03);
    for (int k = 0; k < 3; k++) dma_xfer(1'b1, wvals[k], 1);
    check("t2_done", done, 1);
    for (int i = 0; i < 4; i++) begin
      cpu_read(5'(i), rd);
      check("t2_readback", rd, m_mem[i]);
    end

    // Pointer wrap with random buffer contents
    cpu_write(A_CTRL, 8'h04); model_clr();
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom_range(0, 255));
      cpu_write(5'(i), d);
      m_mem[i] = d;
    end
    cpu_write(A_COUNT, 8'(DEPTH + 2)); m_count = DEPTH + 2; m_ptr = 0;
    cpu_write(A_CTRL, 8'h01);
    for (int k = 0; k < DEPTH + 2; k++) dma_xfer(1'b0, 8'h00, int'($urandom_range(1, 2)));
    check("t3_done", done, 1);
    cpu_read(A_STATUS, rd); check("t3_status", rd, exp_status(1'b0));

    // dack dropped during WAIT
    cpu_write(A_CTRL, 8'h04); model_clr();
    cpu_write(A_COUNT, 8'd2); m_count = 2; m_ptr = 0;
    cpu_write(A_CTRL, 8'h01);
    wait_dreq();
    dack = 1'b1; ior = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_in_wait", ready, 1);
    dack = 1'b0; ior = 1'b0;
    @(posedge clk); #1;
    m_err = 1'b1;
    check("t4_abort_dreq", dreq, 1);
    check("t4_abort_ready", ready, 0);
    cpu_read(A_STATUS, rd); check("t4_status", rd, exp_status(1'b1));
    cpu_read(A_COUNT, rd);  check("t4_count", rd, m_count);
    dma_xfer(1'b0, 8'h00, int'($urandom_range(1, 3)));
    dma_xfer(1'b0, 8'h00, int'($urandom_range(1, 3)));

    // Strobe mismatch: both strobes, then wrong strobe for DIR=0
    cpu_write(A_CTRL, 8'h04); model_clr();
    cpu_write(A_COUNT, 8'd2); m_count = 2; m_ptr = 0;
    cpu_write(A_CTRL, 8'h01);
    wait_dreq();
    dack = 1'b1; ior = 1'b1; iow = 1'b1;
    @(posedge clk); #1;
    check("t5_both_ready", ready, 0);
    check("t5_both_dreq", dreq, 1);
    ior = 1'b0;
    @(posedge clk); #1;
    check("t5_wrong_ready", ready, 0);
    check("t5_wrong_dreq", dreq, 1);
    dack = 1'b0; iow = 1'b0;
    m_err = 1'b1;
    cpu_read(A_STATUS, rd); check("t5_status_err", rd, exp_status(1'b1));
    cpu_write(A_CTRL, 8'h04); model_clr();
    @(posedge clk); #1;
    cpu_read(A_STATUS, rd); check("t5_status_clr", rd, exp_status(1'b0));
    cpu_read(A_COUNT, rd);  check("t5_count_kept", rd, m_count);

    // Reset asserted during WAIT
    cpu_write(A_COUNT, 8'd3); m_count = 3; m_ptr = 0;
    cpu_write(A_CTRL, 8'h01);
    wait_dreq();
    dack = 1'b1; ior = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_in_wait", ready, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", ready, 0);
    check("t6_rst_oe", bus_oe, 0);
    check("t6_rst_dreq", dreq, 0);
    dack = 1'b0; ior = 1'b0;
    m_count = 0; m_ptr = 0; m_done = 1'b0; m_err = 1'b0;
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cpu_read(A_COUNT, rd);  check("t6_count", rd, m_count);
    cpu_read(A_STATUS, rd); check("t6_status", rd, exp_status(1'b0));
    cpu_read(A_CTRL, rd);   check("t6_ctrl", rd, 0);
    cpu_read(5'd0, rd);     check("t6_buf_kept", rd, m_mem[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
